// File: rtl/fir_ram_seq_ctrl.sv
// FIR sequencer: circular sample RAM plus coefficient RAM, drives an external MAC and
// rounds/saturates the accumulator into one output per accepted sample.
module fir_ram_seq_ctrl #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned COEF_WIDTH = 16,
    parameter int unsigned TAPS       = 32,
    parameter int unsigned ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH,
    parameter int unsigned OUT_WIDTH  = 16,
    parameter int unsigned SHIFT      = COEF_WIDTH - 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    input  logic [DATA_WIDTH-1:0]   s_data_i,
    input  logic                    coef_we_i,
    input  logic [$clog2(TAPS)-1:0] coef_addr_i,
    input  logic [COEF_WIDTH-1:0]   coef_data_i,
    output logic                    mac_clr_o,
    output logic                    mac_ena_o,
    output logic [DATA_WIDTH-1:0]   mac_data_o,
    output logic [COEF_WIDTH-1:0]   mac_coef_o,
    input  logic [ACC_WIDTH-1:0]    mac_acc_i,
    output logic                    m_valid_o,
    output logic [OUT_WIDTH-1:0]    m_data_o,
    output logic                    sat_o,
    output logic                    busy_o
);

    localparam int unsigned AddrW = $clog2(TAPS);
    localparam int unsigned SumW  = ACC_WIDTH + 1;

    localparam logic [AddrW-1:0]       LastTap   = AddrW'(TAPS - 1);
    localparam logic [AddrW:0]         TapsExt   = (AddrW + 1)'(TAPS);
    localparam logic signed [SumW-1:0] RoundHalf = SumW'(1) <<< (SHIFT - 1);
    localparam logic signed [SumW-1:0] OutMax    = (SumW'(1) <<< (OUT_WIDTH - 1)) - SumW'(1);
    localparam logic signed [SumW-1:0] OutMin    = -OutMax - SumW'(1);

    typedef enum logic [2:0] {StInit, StIdle, StClr, StRun, StDrain} state_e;

    state_e                 state_q, state_d;
    logic [AddrW-1:0]       cnt_q, cnt_d;
    logic [AddrW-1:0]       wp_q, wp_d;
    logic [AddrW-1:0]       xptr_q, xptr_d;
    logic                   m_valid_q, m_valid_d;
    logic [OUT_WIDTH-1:0]   m_data_q, m_data_d;
    logic                   sat_q, sat_d;

    logic [DATA_WIDTH-1:0]  x_mem [TAPS];
    logic [COEF_WIDTH-1:0]  h_mem [TAPS];
    logic [DATA_WIDTH-1:0]  x_rd_q, x_rd_d;
    logic [COEF_WIDTH-1:0]  h_rd_q, h_rd_d;

    logic                   x_we, h_we;
    logic [AddrW-1:0]       x_waddr, h_waddr, x_raddr, h_raddr;
    logic [DATA_WIDTH-1:0]  x_wdata;
    logic [COEF_WIDTH-1:0]  h_wdata;

    logic signed [SumW-1:0] acc_ext, acc_rnd, acc_shr;
    logic [OUT_WIDTH-1:0]   sat_data;
    logic                   sat_flag;

    function automatic logic [AddrW-1:0] dec_ptr(input logic [AddrW-1:0] p);
        return (p == '0) ? LastTap : p - 1'b1;
    endfunction

    // Round half up, then clamp to the signed output range.
    always_comb begin
        acc_ext = {mac_acc_i[ACC_WIDTH-1], mac_acc_i};
        acc_rnd = acc_ext + RoundHalf;
        acc_shr = acc_rnd >>> SHIFT;
        if (acc_shr > OutMax) begin
            sat_data = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
            sat_flag = 1'b1;
        end else if (acc_shr < OutMin) begin
            sat_data = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
            sat_flag = 1'b1;
        end else begin
            sat_data = acc_shr[OUT_WIDTH-1:0];
            sat_flag = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wp_d      = wp_q;
        xptr_d    = xptr_q;
        m_valid_d = 1'b0;
        m_data_d  = m_data_q;
        sat_d     = sat_q;
        x_we      = 1'b0;
        x_waddr   = wp_q;
        x_wdata   = s_data_i;
        h_we      = 1'b0;
        h_waddr   = coef_addr_i;
        h_wdata   = coef_data_i;
        // In RUN the read for the next tap is issued while the current pair is on the bus.
        x_raddr   = xptr_q;
        h_raddr   = (cnt_q == LastTap) ? '0 : cnt_q + 1'b1;
        s_ready_o = 1'b0;
        busy_o    = 1'b1;
        mac_clr_o = 1'b0;
        mac_ena_o = 1'b0;

        case (state_q)
            StInit: begin
                x_we    = 1'b1;
                h_we    = 1'b1;
                x_waddr = cnt_q;
                h_waddr = cnt_q;
                x_wdata = '0;
                h_wdata = '0;
                if (cnt_q == LastTap) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StIdle: begin
                s_ready_o = 1'b1;
                busy_o    = 1'b0;
                h_we      = coef_we_i && ({1'b0, coef_addr_i} < TapsExt);
                if (s_valid_i) begin
                    x_we    = 1'b1;
                    state_d = StClr;
                end
            end
            StClr: begin
                mac_clr_o = 1'b1;
                x_raddr   = wp_q;
                h_raddr   = '0;
                xptr_d    = dec_ptr(wp_q);
                cnt_d     = '0;
                state_d   = StRun;
            end
            StRun: begin
                mac_ena_o = 1'b1;
                xptr_d    = dec_ptr(xptr_q);
                if (cnt_q == LastTap) begin
                    cnt_d   = '0;
                    state_d = StDrain;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDrain: begin
                if (cnt_q == AddrW'(1)) begin
                    cnt_d     = '0;
                    state_d   = StIdle;
                    m_valid_d = 1'b1;
                    m_data_d  = sat_data;
                    sat_d     = sat_flag;
                    wp_d      = (wp_q == LastTap) ? '0 : wp_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StInit;
        endcase
    end

    // Synchronous read with write-first bypass on an address match.
    always_comb begin
        x_rd_d = (x_we && (x_waddr == x_raddr)) ? x_wdata : x_mem[x_raddr];
        h_rd_d = (h_we && (h_waddr == h_raddr)) ? h_wdata : h_mem[h_raddr];
    end

    always_ff @(posedge clk_i) begin
        if (x_we) begin
            x_mem[x_waddr] <= x_wdata;
        end
        if (h_we) begin
            h_mem[h_waddr] <= h_wdata;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StInit;
            cnt_q     <= '0;
            wp_q      <= '0;
            xptr_q    <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            sat_q     <= 1'b0;
            x_rd_q    <= '0;
            h_rd_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wp_q      <= wp_d;
            xptr_q    <= xptr_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            sat_q     <= sat_d;
            x_rd_q    <= x_rd_d;
            h_rd_q    <= h_rd_d;
        end
    end

    assign mac_data_o = mac_ena_o ? x_rd_q : '0;
    assign mac_coef_o = mac_ena_o ? h_rd_q : '0;
    assign m_valid_o  = m_valid_q;
    assign m_data_o   = m_data_q;
    assign sat_o      = sat_q;

endmodule
